fetch_stage: RTL

Parametrised instruction-fetch stage: the successor to the program_counter / pc_adder / Instruction_Memory trio. It owns the PC, issues sequential word reads to a synchronous-read instruction memory, and buffers returned {pc, instruction} pairs in a prefetch queue. The queue drains to decode through a valid/ready handshake. A redirect input (branch/jump) flushes the queue, discards any in-flight read and restarts fetch at a new PC. It sits between the instruction memory and the decode stage of the core.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch slice.
//   INSTR_BYTES   - size of one instruction word in bytes (PC step)
//   DEFAULT_XLEN  - default PC / instruction width
//   fetch_entry_t - one prefetch queue entry {pc, instr} at the default width
package fetch_pkg;

  localparam int INSTR_BYTES  = 4;
  localparam int DEFAULT_XLEN = 32;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   flush     - empties the FIFO; wins over push and pop in the same cycle
//   push      - write pushData at the tail
//   pushData  - entry to write
//   pop       - drop the head entry
//   count     - number of valid entries (0..DEPTH)
//   head      - current head entry (storage contents, meaningful when count != 0)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  T              pushData,
  input  logic          pop,
  output logic [CW-1:0] count,
  output T              head
);

  localparam int AW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_doPush;
  logic w_doPop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A push into a full FIFO is only accepted when the head leaves in the
  // same cycle; the fetch stage never relies on this, but it keeps the
  // FIFO from corrupting itself if misused.
  assign w_doPush = push && (!w_full || pop);
  assign w_doPop  = pop && !w_empty;

  // Pointers and occupancy. Pointers wrap naturally since DEPTH is a
  // power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; a write during flush is harmless because the
  // pointers are cleared in the same edge.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= pushData;
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rdPtr];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage: owns the PC, issues sequential word reads to a
// synchronous-read instruction memory and buffers {pc, instr} pairs in a
// prefetch queue that drains to decode over valid/ready.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   redirect_valid   - branch/jump redirect this cycle
//   redirect_pc      - new fetch PC (low two bits ignored)
//   imem_req         - memory read request this cycle
//   imem_addr        - word-aligned read byte address
//   imem_rdata       - read data, valid the cycle after imem_req
//   out_valid        - queue head holds an instruction
//   out_ready        - decode accepts the head this cycle
//   out_pc           - PC of the head instruction
//   out_pc_next      - out_pc + 4 (wrapping)
//   out_instr        - head instruction
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_next,
  output logic [XLEN-1:0] out_instr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_reqPc;
  logic            r_inflight;

  logic [CW-1:0]   w_count;
  logic [OW-1:0]   w_occupancy;
  logic            w_slotFree;
  logic            w_pop;
  entry_t          w_head;
  entry_t          w_pushData;
  logic [1:0]      w_unusedPcBits;

  assign w_unusedPcBits = redirect_pc[1:0];

  // A slot is reserved for every read in flight, so a response always has
  // room in the queue when it lands.
  assign w_occupancy = {1'b0, w_count} + OW'(r_inflight);
  assign w_slotFree  = (w_occupancy < OW'(DEPTH));

  assign imem_req  = !rst && !redirect_valid && w_slotFree;
  assign imem_addr = r_pc;

  // PC register and in-flight tracking. A redirect (or reset) clears the
  // in-flight flag, so the response that would otherwise land next cycle
  // is never pushed; the queue flush in the same edge kills the one
  // landing now.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= {RESET_PC[XLEN-1:2], 2'b00};
      r_reqPc    <= {RESET_PC[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_pc    <= r_pc + XLEN'(INSTR_BYTES);
        r_reqPc <= r_pc;
      end
    end
  end

  assign w_pushData = '{pc: r_reqPc, instr: imem_rdata};
  assign w_pop      = out_valid && out_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (r_inflight),
    .pushData (w_pushData),
    .pop      (w_pop),
    .count    (w_count),
    .head     (w_head)
  );

  assign out_valid   = (w_count != '0);
  assign out_pc      = w_head.pc;
  assign out_instr   = w_head.instr;
  assign out_pc_next = w_head.pc + XLEN'(INSTR_BYTES);

endmodule
